// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: control states,
// default operand width and the iteration-counter width helper.
package mult_pkg;

  localparam int unsigned DefWidth = 8;

  // Two-bit state encoding shared by the controller and anything that decodes it.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StRun  = 2'd2,
    StDone = 2'd3
  } mult_state_e;

  // Counter must hold 0..width-1; keep at least one bit for degenerate widths.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  localparam int unsigned DefCntWidth = cnt_width(DefWidth);

endpackage

// File: rtl/seq_mult_datapath.sv
// Datapath for the shift-add multiplier: operand registers, accumulator,
// iteration counter, the WIDTH+1-bit adder and the product register.
module seq_mult_datapath
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 ld_i,       // latch operands, clear accumulator
  input  logic                 clr_i,      // clear iteration counter
  input  logic                 step_i,     // one add/shift iteration
  input  logic                 cap_i,      // capture the post-step result into P
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [2*WIDTH-1:0]   p_o,
  output logic                 last_bit_o
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH:0]     sum;

  // Next-state for all datapath registers; the FSM never raises ld/clr/step together.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_hi_d = acc_hi_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    // Carry lands in sum[WIDTH] and is shifted back into the accumulator MSB.
    sum      = {1'b0, acc_hi_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);

    if (ld_i) begin
      mcand_d  = a_i;
      mplier_d = b_i;
      acc_hi_d = '0;
    end
    if (clr_i) begin
      cnt_d = '0;
    end
    if (step_i) begin
      acc_hi_d = sum[WIDTH:1];
      mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
      cnt_d    = cnt_q + CntW'(1);
    end
    // Capture uses the post-step value so P is valid while done is high.
    if (cap_i) begin
      p_d = {acc_hi_d, mplier_d};
    end
  end

  // Datapath state register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_hi_q <= '0;
      cnt_q    <= '0;
      p_q      <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_hi_q <= acc_hi_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
    end
  end

  assign p_o        = p_q;
  assign last_bit_o = (cnt_q == CntW'(WIDTH - 1));

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential unsigned shift-add multiplier: one multiplier bit per clock,
// controller FSM here, arithmetic in seq_mult_datapath.
module seq_shift_add_mult
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] P,
  output logic               busy,
  output logic               done
);

  mult_state_e state_q, state_d;
  logic        ld, clr, step, cap;
  logic        last_bit;

  // Next-state and datapath controls; start only matters in idle.
  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    clr     = 1'b0;
    step    = 1'b0;
    cap     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          ld      = 1'b1;
          state_d = StLoad;
        end
      end
      StLoad: begin
        clr     = 1'b1;
        state_d = StRun;
      end
      StRun: begin
        step = 1'b1;
        if (last_bit) begin
          cap     = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Status outputs decoded purely from state.
  always_comb begin
    busy = (state_q == StLoad) || (state_q == StRun);
    done = (state_q == StDone);
  end

  seq_mult_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk_i      (clk),
    .reset_i    (reset),
    .ld_i       (ld),
    .clr_i      (clr),
    .step_i     (step),
    .cap_i      (cap),
    .a_i        (A),
    .b_i        (B),
    .p_o        (P),
    .last_bit_o (last_bit)
  );

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Self-checking bench for seq_shift_add_mult against a cycle-timeline model.
module tb_seq_shift_add_mult;

  localparam int W = 8;

  logic           clk;
  logic           reset;
  logic           start;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic [2*W-1:0] P;
  logic           busy;
  logic           done;

  int checks;
  int errors;

  // Reference model: t counts edges since the accepting edge (0 = idle).
  // Accepting edge -> t=1 (load), then W run cycles, then t=W+2 is the done cycle.
  int unsigned    t;
  logic [2*W-1:0] pend;
  logic [2*W-1:0] exp_p;
  int             done_seen;

  seq_shift_add_mult #(
    .WIDTH(W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .P     (P),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock, update the model from the inputs seen at the edge, compare outputs.
  task automatic tick();
    logic           s, r;
    logic [W-1:0]   a, b;
    s = start; r = reset; a = A; b = B;
    @(posedge clk);
    #1;
    if (r) begin
      t     = 0;
      exp_p = '0;
    end else if (t == 0) begin
      if (s) begin
        t    = 1;
        pend = (2*W)'(a) * (2*W)'(b);
      end
    end else if (t == W + 2) begin
      t = 0;
    end else begin
      t++;
      if (t == W + 2) exp_p = pend;
    end
    if (done === 1'b1) done_seen++;
    check("busy", {31'd0, busy}, {31'd0, (t >= 1 && t <= W + 1)});
    check("done", {31'd0, done}, {31'd0, (t == W + 2)});
    check("P", {16'd0, P}, {16'd0, exp_p});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One start pulse with the given operands, then run until back in idle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    A = a; B = b; start = 1'b1;
    tick();
    start = 1'b0;
    A = W'($urandom); B = W'($urandom);
    ticks(W + 2);
  endtask

  initial begin
    checks = 0; errors = 0;
    t = 0; pend = '0; exp_p = '0; done_seen = 0;
    reset = 1'b1; start = 1'b0; A = '0; B = '0;

    // Reset state
    ticks(2);
    reset = 1'b0;
    tick();

    // Basic multiplies, P must hold afterwards
    done_seen = 0;
    run_op(8'd3, 8'd8);
    check("basic_done_count", done_seen, 1);
    check("basic_P", {16'd0, P}, 32'h0018);
    ticks(3);
    done_seen = 0;
    run_op(8'd8, 8'd4);
    check("second_done_count", done_seen, 1);
    check("second_P", {16'd0, P}, 32'h0020);

    // Boundary operands, and done latency for each
    run_op(8'd255, 8'd255);
    check("max_P", {16'd0, P}, 32'hFE01);
    run_op(8'd0, 8'd200);
    check("zero_P", {16'd0, P}, 32'h0000);

    // start held high; operands change mid-run of the first op
    done_seen = 0;
    A = 8'd5; B = 8'd7; start = 1'b1;
    ticks(4);
    A = 8'd9; B = 8'd9;
    ticks(36);
    start = 1'b0;
    check("held_done_count", done_seen, 3);
    ticks(W + 3);
    check("held_last_P", {16'd0, P}, 32'd81);

    // Reset during the fourth run cycle; no done, P cleared
    done_seen = 0;
    A = 8'd100; B = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    ticks(4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_P", {16'd0, P}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    ticks(W + 3);
    check("abort_no_done", done_seen, 0);
    run_op(8'd100, 8'd3);
    check("after_abort_P", {16'd0, P}, 32'd300);

    // start pulsed during run is ignored
    done_seen = 0;
    A = 8'd2; B = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    ticks(3);
    start = 1'b1; A = 8'd50; B = 8'd50;
    tick();
    start = 1'b0;
    ticks(W - 2);
    check("ignored_start_done_count", done_seen, 1);
    check("ignored_start_P", {16'd0, P}, 32'd4);
    ticks(2);

    // Random operations with random idle gaps and stray start pulses
    for (int k = 0; k < 25; k++) begin
      A = W'($urandom); B = W'($urandom); start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < W + 2; c++) begin
        start = ($urandom_range(0, 3) == 0);
        A = W'($urandom); B = W'($urandom);
        tick();
      end
      start = 1'b0;
      ticks($urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
